fp_class_arbiter: RTL and testbench
===================================

Name: fp_class_arbiter

Overview:
- Shares one FCLASS datapath between NUM_REQ requesters, for example the integer-pipe FCLASS.S issue and the FP-CSR/exception probe path.
- Round-robin arbitration over valid/ready request ports. The granted operand is registered and classified by an internal instance of floating_point_classify.
- The tagged result is returned on a single valid/ready response port with a one-entry output slot, giving throughput of 1 per cycle.
- Also keeps a saturating count of signaling-NaN classifications.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the source-index field; must satisfy 2**ID_W >= NUM_REQ.
- TAG_W, 5, opaque tag width (e.g. rd index), returned unchanged.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush of the output slot.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- i_req_operand  in  NUM_REQ*32  packed single-precision operands; requester k uses [32k+31:32k].
- i_req_tag  in  NUM_REQ*TAG_W  packed tags.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accept.
- o_rsp_class  out  10  one-hot class vector.
- o_rsp_result  out  32  o_rsp_class zero-extended, written to rd.
- o_rsp_src  out  ID_W  index of the granted requester.
- o_rsp_tag  out  TAG_W  tag of the granted request.
- o_snan_cnt  out  16  saturating count of sNaN results delivered.

Behaviour:
- **Reset (async, i_rst=1)**
  - o_rsp_valid=0, slot operand/src/tag=0, RR pointer=0, o_snan_cnt=0.
  - o_req_ready=0 while reset is asserted.
  - An in-flight response is discarded.
- **Class encoding (one-hot)**
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0.
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf.
  - bit8 sNaN, bit9 qNaN.
  - Exactly one bit is set whenever o_rsp_valid=1.
- **Slot-free condition**
  - slot_free = (!o_rsp_valid || i_rsp_ready) && !i_flush.
- **Arbitration (combinational)**
  - Search valid requesters starting at index ptr, ascending, wrapping modulo NUM_REQ. The first hit is the grant g.
  - o_req_ready[g] = slot_free; all other ready bits are 0.
  - Ready may depend on i_req_valid.
  - Requesters hold valid, operand and tag stable until accepted.
- **Accept (i_req_valid[g] && o_req_ready[g] at clock edge)**
  - Slot captures operand[g], tag[g] and src=g; o_rsp_valid<=1.
  - ptr <= (g+1) mod NUM_REQ.
- **Latency**
  - Accept at edge N makes the response visible after edge N, i.e. sampled at edge N+1.
  - o_rsp_class is combinational from the registered operand only; no request input feeds a response output combinationally.
- **Hold and retire**
  - While o_rsp_valid && !i_rsp_ready: all response outputs hold, and no accept occurs.
  - Retire with no new accept: o_rsp_valid<=0; the slot contents are don't-care but stable.
  - Retire and accept in the same cycle: back-to-back, the slot is reloaded and o_rsp_valid stays 1.
- **Flush (i_flush=1)**
  - o_rsp_valid<=0 at the edge. No accept in that cycle.
  - ptr and o_snan_cnt are unchanged.
  - i_flush has priority over i_rsp_ready.
- **o_snan_cnt**
  - Increments by 1 on each response handshake (o_rsp_valid && i_rsp_ready && !i_flush) whose class bit8=1.
  - Saturates at 16'hFFFF.
  - Flushed responses are not counted.
- **No valid requests:** all ready bits=0 and ptr is unchanged.
- **NUM_REQ=1:** ptr is constant 0.

Test Plan:
- Single requester 0 sends 0x3F800000 (+1.0), consumer ready → o_rsp_valid one cycle after accept; class=10'h040, result=32'h00000040, src=0, tag returned.
- Sweep through requester 0: 0x80000000 → 10'h008; 0xFF800000 → 10'h001; 0x00000001 → 10'h020; 0x7FC00000 → 10'h200; 0x7F800001 → 10'h100 with o_snan_cnt 0→1.
- Both requesters valid continuously, consumer always ready → grants alternate 0,1,0,1. One accept per cycle; src alternates; tags match their operands.
- Hold i_rsp_ready=0 for 3 cycles with a response pending → outputs stable, o_req_ready=0. When ready rises, retire and next accept happen in the same cycle.
- Assert i_flush with a response pending and requester 1 valid → o_rsp_valid=0 next cycle, no accept that cycle, sNaN not counted; requester 1 is accepted the following cycle.
- Assert i_rst asynchronously mid-stream (between edges) → o_rsp_valid, o_req_ready and o_snan_cnt drop to 0 immediately. After release, requester 0 wins first with ptr=0. Separately, force o_snan_cnt to 16'hFFFF and deliver another sNaN → stays 16'hFFFF.

Source files
------------

// File: rtl/floating_point_classify.sv
// Single-precision FCLASS: maps an IEEE-754 binary32 operand to the RISC-V
// one-hot class vector.
module floating_point_classify (
    input  logic [31:0] i_operand,
    output logic [9:0]  o_class
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;

    assign w_sign = i_operand[31];
    assign w_exp  = i_operand[30:23];
    assign w_mant = i_operand[22:0];

    always_comb begin
        o_class = '0;
        if (w_exp == 8'hFF) begin
            if (w_mant == '0) begin
                o_class[w_sign ? 0 : 7] = 1'b1;
            end else if (w_mant[22]) begin
                o_class[9] = 1'b1;
            end else begin
                o_class[8] = 1'b1;
            end
        end else if (w_exp == 8'h00) begin
            if (w_mant == '0) begin
                o_class[w_sign ? 3 : 4] = 1'b1;
            end else begin
                o_class[w_sign ? 2 : 5] = 1'b1;
            end
        end else begin
            o_class[w_sign ? 1 : 6] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_class_arbiter.sv
// Round-robin arbiter sharing one FCLASS datapath between NUM_REQ requesters,
// with a one-entry response slot and a saturating sNaN counter.
module fp_class_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*32-1:0]    i_req_operand,
    input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [9:0]               o_rsp_class,
    output logic [31:0]              o_rsp_result,
    output logic [ID_W-1:0]          o_rsp_src,
    output logic [TAG_W-1:0]         o_rsp_tag,
    output logic [15:0]              o_snan_cnt
);

    logic              r_valid;
    logic [31:0]       r_operand;
    logic [ID_W-1:0]   r_src;
    logic [TAG_W-1:0]  r_tag;
    logic [ID_W-1:0]   r_ptr;
    logic [15:0]       r_snan_cnt;

    logic              w_slot_free;
    logic              w_found;
    logic              w_accept;
    logic              w_snan_fire;
    logic [ID_W-1:0]   w_grant;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [31:0]       w_operand;
    logic [TAG_W-1:0]  w_tag;
    logic [9:0]        w_class;

    assign w_slot_free = (!r_valid || i_rsp_ready) && !i_flush;

    // Two passes: indices at or above ptr first, then the wrapped-around low indices.
    always_comb begin
        w_found   = 1'b0;
        w_grant   = '0;
        w_operand = '0;
        w_tag     = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j >= 32'(r_ptr)) && i_req_valid[j]) begin
                w_found   = 1'b1;
                w_grant   = ID_W'(j);
                w_operand = i_req_operand[32*j +: 32];
                w_tag     = i_req_tag[TAG_W*j +: TAG_W];
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j < 32'(r_ptr)) && i_req_valid[j]) begin
                w_found   = 1'b1;
                w_grant   = ID_W'(j);
                w_operand = i_req_operand[32*j +: 32];
                w_tag     = i_req_tag[TAG_W*j +: TAG_W];
            end
        end
    end

    assign w_accept = w_found && w_slot_free && !i_rst;

    always_comb begin
        o_req_ready = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            o_req_ready[j] = w_accept && (32'(w_grant) == j);
        end
    end

    always_comb begin
        w_ptr_nxt = '0;
        if (32'(w_grant) + 32'd1 < NUM_REQ) begin
            w_ptr_nxt = ID_W'(32'(w_grant) + 32'd1);
        end
    end

    floating_point_classify u_classify (
        .i_operand (r_operand),
        .o_class   (w_class)
    );

    assign w_snan_fire = r_valid && i_rsp_ready && !i_flush && w_class[8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_operand  <= '0;
            r_src      <= '0;
            r_tag      <= '0;
            r_ptr      <= '0;
            r_snan_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_operand <= w_operand;
                r_src     <= w_grant;
                r_tag     <= w_tag;
                r_ptr     <= w_ptr_nxt;
            end else if (i_flush || i_rsp_ready) begin
                r_valid <= 1'b0;
            end
            if (w_snan_fire && (r_snan_cnt != 16'hFFFF)) begin
                r_snan_cnt <= r_snan_cnt + 16'd1;
            end
        end
    end

    assign o_rsp_valid  = r_valid;
    assign o_rsp_class  = w_class;
    assign o_rsp_result = {22'b0, w_class};
    assign o_rsp_src    = r_src;
    assign o_rsp_tag    = r_tag;
    assign o_snan_cnt   = r_snan_cnt;

endmodule

// File: tb/tb_fp_class_arbiter.sv
// Directed bench for fp_class_arbiter with two requesters and hand-computed expectations.
module tb_fp_class_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;
    localparam int unsigned TAG_W   = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_operand;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [9:0]               rsp_class;
    logic [31:0]              rsp_result;
    logic [ID_W-1:0]          rsp_src;
    logic [TAG_W-1:0]         rsp_tag;
    logic [15:0]              snan_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_src;

    always #5 clk = ~clk;

    fp_class_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_operand (req_operand),
        .i_req_tag     (req_tag),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_class   (rsp_class),
        .o_rsp_result  (rsp_result),
        .o_rsp_src     (rsp_src),
        .o_rsp_tag     (rsp_tag),
        .o_snan_cnt    (snan_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated request from requester k, consumer always ready.
    task automatic send(input int k, input logic [31:0] op, input logic [4:0] tg,
                        input logic [9:0] cls);
        req_valid = '0;
        req_valid[k] = 1'b1;
        req_operand[32*k +: 32] = op;
        req_tag[TAG_W*k +: TAG_W] = tg;
        rsp_ready = 1'b1;
        #1 check("send_ready", 32'(req_ready), 32'(1 << k));
        @(posedge clk); #1;
        req_valid = '0;
        check("send_valid", 32'(rsp_valid), 32'd1);
        check("send_class", 32'(rsp_class), 32'(cls));
        check("send_result", rsp_result, {22'b0, cls});
        check("send_src", 32'(rsp_src), 32'(k));
        check("send_tag", 32'(rsp_tag), 32'(tg));
        @(posedge clk); #1;
        check("send_retire", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_operand = '0; req_tag = '0;
        rsp_ready = 1'b0;
        #2;
        req_valid = 2'b01;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_snan", 32'(snan_cnt), 32'd0);
        check("rst_src", 32'(rsp_src), 32'd0);
        check("rst_tag", 32'(rsp_tag), 32'd0);
        check("rst_class", 32'(rsp_class), 32'h010);
        #5 rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'b01);
        req_valid = '0;
        @(posedge clk); #1;
        check("idle_valid", 32'(rsp_valid), 32'd0);

        send(0, 32'h3F800000, 5'h11, 10'h040);
        send(0, 32'h80000000, 5'h02, 10'h008);
        send(0, 32'hFF800000, 5'h03, 10'h001);
        send(0, 32'h00000001, 5'h04, 10'h020);
        send(0, 32'h7FC00000, 5'h05, 10'h200);
        check("snan_before", 32'(snan_cnt), 32'd0);
        send(0, 32'h7F800001, 5'h06, 10'h100);
        check("snan_after", 32'(snan_cnt), 32'd1);

        // Pointer now at 1, so requester 1 wins first.
        req_operand = {32'hBF800000, 32'h3F800000};
        req_tag = {5'h15, 5'h0A};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        exp_src = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_ready", 32'(req_ready), (exp_src == 1) ? 32'b10 : 32'b01);
            @(posedge clk); #1;
            check("rr_valid", 32'(rsp_valid), 32'd1);
            check("rr_src", 32'(rsp_src), 32'(exp_src));
            check("rr_tag", 32'(rsp_tag), (exp_src == 1) ? 32'h15 : 32'h0A);
            check("rr_class", 32'(rsp_class), (exp_src == 1) ? 32'h002 : 32'h040);
            exp_src = 1 - exp_src;
        end

        rsp_ready = 1'b0;
        #1 check("hold_ready0", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_src", 32'(rsp_src), 32'd0);
            check("hold_tag", 32'(rsp_tag), 32'h0A);
            check("hold_class", 32'(rsp_class), 32'h040);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 check("b2b_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        check("b2b_valid", 32'(rsp_valid), 32'd1);
        check("b2b_src", 32'(rsp_src), 32'd1);
        check("b2b_tag", 32'(rsp_tag), 32'h15);
        req_valid = '0;
        @(posedge clk); #1;
        check("b2b_retire", 32'(rsp_valid), 32'd0);

        // Pending sNaN flushed while requester 1 waits.
        req_valid = 2'b10;
        req_operand[63:32] = 32'h7F800001;
        req_tag[9:5] = 5'h03;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("fl_pend_valid", 32'(rsp_valid), 32'd1);
        check("fl_pend_class", 32'(rsp_class), 32'h100);
        req_operand[63:32] = 32'h00000000;
        req_tag[9:5] = 5'h07;
        flush = 1'b1;
        rsp_ready = 1'b1;
        #1 check("fl_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("fl_valid", 32'(rsp_valid), 32'd0);
        check("fl_snan", 32'(snan_cnt), 32'd1);
        flush = 1'b0;
        #1 check("fl_next_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        check("fl_next_valid", 32'(rsp_valid), 32'd1);
        check("fl_next_src", 32'(rsp_src), 32'd1);
        check("fl_next_tag", 32'(rsp_tag), 32'h07);
        check("fl_next_class", 32'(rsp_class), 32'h010);
        req_valid = '0;
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle with a pending sNaN and pointer at 1.
        req_valid = 2'b01;
        req_operand[31:0] = 32'h7F800001;
        req_tag[4:0] = 5'h01;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("ar_pend_valid", 32'(rsp_valid), 32'd1);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #2;
        check("ar_snan_pre", 32'(snan_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(rsp_valid), 32'd0);
        check("ar_ready", 32'(req_ready), 32'd0);
        check("ar_snan", 32'(snan_cnt), 32'd0);
        #1 rst = 1'b0;
        #1 check("ar_ptr_ready", 32'(req_ready), 32'b01);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("ar_src", 32'(rsp_src), 32'd0);
        check("ar_tag", 32'(rsp_tag), 32'h01);
        check("ar_class", 32'(rsp_class), 32'h100);
        req_valid = '0;
        @(posedge clk); #1;
        check("ar_snan_inc", 32'(snan_cnt), 32'd1);

        // Saturation of the sNaN counter.
        force dut.r_snan_cnt = 16'hFFFF;
        #1 release dut.r_snan_cnt;
        send(0, 32'h7F800001, 5'h1F, 10'h100);
        check("snan_sat", 32'(snan_cnt), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
